serial_subtractor: RTL and testbench

Parametrised, bit-serial subtract/complement unit: the sequential successor to our combinational half-subtractor, ones'-complement and two's-complement blocks. It folds all three operations, plus reverse subtraction, into one WIDTH-bit datapath. That datapath is a single full-subtractor cell, a borrow flip-flop and shift registers, sequenced by a small FSM with a start/busy/done handshake. It sits between the board switch/button logic and the LED outputs of the top level, and can also serve as a reusable arithmetic block elsewhere.

---
 rtl/serial_subtractor.sv | 155 +++++++++++++++
 tb/tb_serial_subtractor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtract/complement unit. One full-subtractor cell, a borrow
//   flip-flop and three shift registers process one bit per clock, LSB first,
//   sequenced by an IDLE/RUN/DONE FSM.
//
//   Handshake: start is sampled only in IDLE or DONE. An accepted start
//   captures the operands and moves to RUN. busy is high for the WIDTH RUN
//   cycles. done is then high for exactly one cycle, and result/borrow/overflow
//   are valid from that cycle on. Those outputs hold their value until the next
//   DONE. start seen during RUN is dropped. busy and done are never high
//   together.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset
//   start     request a new operation
//   mode      00: a-b   01: ~a   10: 0-a   11: b-a
//   a, b      operands (WIDTH bits), captured on an accepted start
//   busy      operation in progress
//   done      one-cycle completion pulse
//   result    difference or complement
//   borrow    unsigned borrow out of the MSB
//   overflow  signed (two's-complement) overflow
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] x_q;      // minuend shift register
    logic [WIDTH-1:0] y_q;      // subtrahend shift register
    logic [WIDTH-1:0] r_q;      // result bits, filled from the MSB end
    logic             bin_q;    // borrow carried between bit cycles
    logic [CW-1:0]    cnt_q;
    logic [1:0]       mode_q;

    logic             cmp_mode;
    logic             d_bit;
    logic             bout;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

    // Full-subtractor cell. Ones' complement just inverts the minuend bit and
    // never produces a borrow.
    assign cmp_mode = (mode_q == 2'b01);
    always_comb begin
        d_bit = 1'b0;
        bout  = 1'b0;
        if (cmp_mode) begin
            d_bit = ~x_q[0];
            bout  = 1'b0;
        end else begin
            d_bit = x_q[0] ^ y_q[0] ^ bin_q;
            bout  = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & bin_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            r_q      <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= 2'b00;
            result   <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Every mode is reduced to x - y, except ones' complement,
                // which only uses x.
                unique case (mode)
                    2'b00: begin x_q <= a;  y_q <= b;  end
                    2'b11: begin x_q <= b;  y_q <= a;  end
                    2'b10: begin x_q <= '0; y_q <= a;  end
                    default: begin x_q <= a; y_q <= '0; end
                endcase
                bin_q  <= 1'b0;
                cnt_q  <= '0;
                mode_q <= mode;
            end else if (state_q == RUN) begin
                x_q   <= x_q >> 1;
                y_q   <= y_q >> 1;
                r_q   <= {d_bit, r_q[WIDTH-1:1]};
                bin_q <= bout;
                cnt_q <= last_bit ? '0 : cnt_q + 1'b1;
                // The outputs are loaded on the MSB cycle so that they are
                // already visible in the DONE cycle. x_q[0]/y_q[0]/d_bit are
                // the MSB bits at this point.
                if (last_bit) begin
                    result   <= {d_bit, r_q[WIDTH-1:1]};
                    borrow   <= bout;
                    overflow <= !cmp_mode && (x_q[0] != y_q[0]) && (d_bit != x_q[0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         borrow;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .borrow(borrow), .overflow(overflow)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: every mode is x - y on plain integers.
  function automatic void ref_op(input logic [1:0] m, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 output logic [W-1:0] r, output logic br, output logic ov);
    int x, y, sx, sy, diff;
    if (m == 2'b01) begin
      r = ~aa; br = 1'b0; ov = 1'b0;
      return;
    end
    case (m)
      2'b00:   begin x = int'(aa); y = int'(bb); end
      2'b11:   begin x = int'(bb); y = int'(aa); end
      default: begin x = 0;        y = int'(aa); end
    endcase
    diff = x - y;
    r  = diff[W-1:0];
    br = (x < y);
    sx = (x >= (1 << (W-1))) ? x - (1 << W) : x;
    sy = (y >= (1 << (W-1))) ? y - (1 << W) : y;
    ov = ((sx - sy) > ((1 << (W-1)) - 1)) || ((sx - sy) < -(1 << (W-1)));
  endfunction

  // Timeline model: ph = -1 idle, 1..W busy cycles, W+1 done cycle.
  int           ph = -1;
  bit           mv = 1'b0;
  logic [W-1:0] er = '0, pr = '0;
  logic         eb = 1'b0, eo = 1'b0, pb = 1'b0, po = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ph = -1; er = '0; eb = 1'b0; eo = 1'b0; mv = 1'b1;
    end else if ((ph == -1 || ph == W + 1) && start) begin
      ref_op(mode, a, b, pr, pb, po);
      ph = 1;
    end else if (ph >= 1 && ph < W) begin
      ph++;
    end else if (ph == W) begin
      ph = W + 1; er = pr; eb = pb; eo = po;
    end else if (ph == W + 1) begin
      ph = -1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mv) begin
      check("busy", 32'(busy), 32'(ph >= 1 && ph <= W));
      check("done", 32'(done), 32'(ph == W + 1));
      check("result", 32'(result), 32'(er));
      check("borrow", 32'(borrow), 32'(eb));
      check("overflow", 32'(overflow), 32'(eo));
    end
  end

  // Drive one start pulse; returns #1 after the accepting edge (cycle 1 of RUN).
  task automatic start_op(input logic [1:0] m, input logic [W-1:0] aa, input logic [W-1:0] bb);
    start = 1'b1; mode = m; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done; n is the cycle number counted from the accepting edge.
  task automatic wait_done(inout int n, output int busy_cycles, input bit noise);
    busy_cycles = 0;
    while (!done && n < 40) begin
      if (busy) busy_cycles++;
      if (noise) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 32'(n), 32'(W + 1));
  endtask

  task automatic directed(input string name, input logic [1:0] m, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, input logic [W-1:0] xr, input logic xb, input logic xo);
    int n, bc;
    start_op(m, aa, bb);
    n = 1;
    wait_done(n, bc, 1'b0);
    check({name, "_latency"}, 32'(n), 32'(W + 1));
    check({name, "_busy_cycles"}, 32'(bc), 32'(W));
    check({name, "_result"}, 32'(result), 32'(xr));
    check({name, "_borrow"}, 32'(borrow), 32'(xb));
    check({name, "_overflow"}, 32'(overflow), 32'(xo));
    @(posedge clk); #1;
  endtask

  initial begin
    int n, bc;
    logic [W-1:0] rr;
    logic rb, ro;

    // reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    @(posedge clk); #1;

    // hand-computed literal cases
    directed("sub",      2'b00, 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    directed("sub_brw",  2'b00, 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
    directed("rsub",     2'b11, 8'h12, 8'h35, 8'h23, 1'b0, 1'b0);
    directed("ovf_a",    2'b00, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    directed("ovf_b",    2'b00, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    directed("ones",     2'b01, 8'h5A, 8'h77, 8'hA5, 1'b0, 1'b0);
    directed("twos",     2'b10, 8'h5A, 8'h33, 8'hA6, 1'b1, 1'b0);
    directed("twos_0",   2'b10, 8'h00, 8'h33, 8'h00, 1'b0, 1'b0);
    directed("twos_min", 2'b10, 8'h80, 8'h00, 8'h80, 1'b1, 1'b1);

    // start held high through RUN: no restart, done at cycle 9
    start = 1'b1; mode = 2'b00; a = 8'h35; b = 8'h12;
    @(posedge clk); #1;
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("held_latency", 32'(n), 32'(W + 1));
    check("held_result", 32'(result), 32'h23);
    @(posedge clk); #1;

    // back-to-back start in the DONE cycle
    start_op(2'b00, 8'h35, 8'h12);
    n = 1;
    wait_done(n, bc, 1'b0);
    check("b2b_first", 32'(result), 32'h23);
    start = 1'b1; a = 8'h10; b = 8'h01;
    @(posedge clk); #1;
    n++;
    start = 1'b0;
    check("b2b_busy_next", 32'(busy), 32'd1);
    wait_done(n, bc, 1'b0);
    check("b2b_latency", 32'(n), 32'(2 * (W + 1)));
    check("b2b_result", 32'(result), 32'h0F);
    @(posedge clk); #1;

    // reset during RUN cycle 4
    start_op(2'b00, 8'h35, 8'h12);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_borrow", 32'(borrow), 32'd0);
    repeat (12) begin
      check("abort_no_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    directed("after_abort", 2'b00, 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);

    // randomized operations with start noise during RUN
    for (int i = 0; i < 150; i++) begin
      logic [1:0]   m;
      logic [W-1:0] ra, rbv;
      m = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rbv = W'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 8'h80;
      if ($urandom_range(0, 7) == 0) rbv = 8'h00;
      ref_op(m, ra, rbv, rr, rb, ro);
      start_op(m, ra, rbv);
      n = 1;
      wait_done(n, bc, 1'b1);
      check("rand_latency", 32'(n), 32'(W + 1));
      check("rand_result", 32'(result), 32'(rr));
      check("rand_flags", {30'd0, borrow, overflow}, {30'd0, rb, ro});
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
